prog_sequence_generator: RTL and testbench
==========================================

# prog_sequence_generator

Parametrised, run-time programmable sequence generator. A DEPTH-entry table of WIDTH-bit values is written through a simple write port, and the block steps through entries 0..last on each enabled clock. Three modes are supported: loop, one-shot and ping-pong. It sits where the fixed 4-bit sequence block sat and feeds pattern/stimulus values to downstream logic, with busy/done status for a controller.

## Interface
- WIDTH, 4, bit width of each sequence value and of `c`.
- DEPTH, 8, number of table entries (≥2).
- AW, 3, index width; must equal clog2(DEPTH).

- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk externally).
- en  in  1  advance enable; one step per clk edge while high and running.
- start  in  1  begin (or restart) a run at index 0; latches `last` and `mode`.
- last  in  AW  index of the final entry (length = last+1).
- mode  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 treated as loop.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  WIDTH  table write data.
- c  out  WIDTH  current sequence value (registered).
- idx  out  AW  current table index.
- busy  out  1  high while running.
- done  out  1  one-cycle pulse at end of sequence or each return to index 0.

## Operation
- States: IDLE, RUN. A direction flag (up/down) is used only in ping-pong.
- Reset (rst=0): state IDLE, c=0, idx=0, busy=0, done=0, dir=up, table[i]=i mod 2^WIDTH (identity sequence).
- IDLE: en is ignored; c/idx hold. start → RUN, idx=0, c=table[0], dir=up, last_q=last, mode_q=mode.
- RUN, en=0: all outputs hold; done=0.
- RUN, en=1, next index:
  - loop: idx<last_q → idx+1; idx==last_q → 0 with done=1.
  - one-shot: idx<last_q → idx+1; idx==last_q → IDLE, done=1, c and idx hold the last value.
  - ping-pong: up: idx+1 until last_q, then reverse; down: idx-1 until 0, then reverse; done=1 on the step that lands on index 0.
  - last_q==0: loop and ping-pong stay at 0 with done=1 every en; one-shot ends on the first en.
- c is loaded with table[next idx] on the same edge that idx updates, so c==table[idx] as of that fetch.
- start has priority over en in any state: a start while running restarts at index 0 with done=0.
- Writes are allowed in any state. A write to an entry takes effect on that entry's next fetch. c does not change on a write alone.
- A write and fetch of the same address on the same edge: c gets wr_data (write-first bypass).
- Changes to last/mode while running are ignored until the next start.
- Index arithmetic is AW-bit unsigned; last_q bounds it, so idx never exceeds last_q.

## Timing
- All outputs are registered and change only on rising clk, except reset, which clears asynchronously.
- Start latency: start sampled at edge k → busy=1, idx=0, c=table[0] visible after edge k.
- Step latency: en sampled at edge k → new idx/c after edge k. Throughput is one value per clock.
- done is high for exactly the cycle following the terminating edge. In one-shot, busy falls on that same edge.
- Reset mid-run: c, idx, busy, done and table return to their reset values immediately. There is no pending state after rst deasserts, and a start is required to run.

## Test plan
- Default table, mode=00, last=7, start then en=1 for 10 cycles → c=0,1,…,7,0,1; done high only on the 7→0 cycle; busy stays 1.
- Write table[0..3]={3,9,1,14}, mode=01, last=3, start, en=1 → c=3,9,1,14; then busy=0, done pulses once, c holds 14; further en has no effect.
- Default table, mode=10, last=3 → c=0,1,2,3,2,1,0,1,2; done at each arrival at 0. last=0 loop → c stays 0, done every en cycle.
- Mid-run en low for 3 cycles at c=5 → c, idx hold at 5, done=0; resumes 6,7. A start at c=6 → next c=table[0], no done pulse.
- Write table[4]=11 on the same edge as the step 3→4 → c=11 (bypass). Change last to 2 mid-run → ignored until the next start.
- Pull rst low between edges at c=9 → c=0, idx=0, busy=0 without a clock edge. After release, table reads back as the identity sequence.

Source files
------------

// File: rtl/prog_sequence_generator.sv
// prog_sequence_generator
//   Run-time programmable sequence generator. A DEPTH-entry table of
//   WIDTH-bit values (identity after reset) is stepped through 0..last in
//   loop, one-shot or ping-pong order, one entry per enabled clock.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   en              advance enable (ignored while idle)
//   start           (re)start a run at index 0, latching last/mode
//   last, mode      final index, 00 loop / 01 one-shot / 10 ping-pong / 11 loop
//   wr_en/addr/data table write port, usable in any state
//   c, idx          current value and table index (registered)
//   busy, done      running flag, one-cycle end/wrap pulse
module prog_sequence_generator #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [AW-1:0]    last,
  input  logic [1:0]       mode,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] c,
  output logic [AW-1:0]    idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;    // 1 = counting down (ping-pong only)
  logic [AW-1:0]    last_q, last_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] tbl_d [DEPTH];

  logic [AW-1:0]    nidx;
  logic             fetch;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    last_d  = last_q;
    mode_d  = mode_q;
    tbl_d   = tbl_q;
    nidx    = idx_q;
    fetch   = 1'b0;

    if (wr_en && (int'(wr_addr) < DEPTH)) tbl_d[wr_addr] = wr_data;

    if (start) begin
      state_d = S_RUN;
      busy_d  = 1'b1;
      dir_d   = 1'b0;
      last_d  = last;
      mode_d  = mode;
      nidx    = '0;
      fetch   = 1'b1;
    end else if (state_q == S_RUN && en) begin
      case (mode_q)
        2'b01: begin
          if (idx_q == last_q) begin
            // final entry already shown: c/idx hold, run ends
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            nidx  = idx_q + AW'(1);
            fetch = 1'b1;
          end
        end
        2'b10: begin
          if (last_q == '0)           nidx = '0;
          else if (!dir_q) begin
            if (idx_q == last_q) begin
              nidx  = idx_q - AW'(1);
              dir_d = 1'b1;
            end else begin
              nidx  = idx_q + AW'(1);
            end
          end else                    nidx = idx_q - AW'(1);
          // landing on 0 ends a half-cycle: pulse done and head back up
          if (nidx == '0) begin
            done_d = 1'b1;
            dir_d  = 1'b0;
          end
          fetch = 1'b1;
        end
        default: begin
          if (idx_q == last_q) begin
            nidx   = '0;
            done_d = 1'b1;
          end else begin
            nidx   = idx_q + AW'(1);
          end
          fetch = 1'b1;
        end
      endcase
    end

    if (fetch) begin
      idx_d = nidx;
      // write-first bypass when the fetched entry is written this edge
      c_d   = (wr_en && wr_addr == nidx) ? wr_data : tbl_q[nidx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      last_q  <= '0;
      mode_q  <= '0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= WIDTH'(i);
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      tbl_q   <= tbl_d;
    end
  end

  assign c    = c_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_prog_sequence_generator.sv
// Directed bench for prog_sequence_generator (WIDTH=4, DEPTH=8).
// Inputs change 1ns after each rising edge; outputs are sampled at the same
// point, so every check sees the result of the preceding edge.
module tb_prog_sequence_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, start = 1'b0, wr_en = 1'b0;
  logic [2:0] last = '0, wr_addr = '0;
  logic [1:0] mode = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] c;
  logic [2:0] idx;
  logic       busy, done;

  int ncmp = 0;
  int nerr = 0;

  prog_sequence_generator #(.WIDTH(4), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .last(last), .mode(mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .c(c), .idx(idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; #1; rst = 1'b1;
    en = 1'b0; start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] l, input logic [1:0] m);
    start = 1'b1; last = l; mode = m;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    e = 9'h000;
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL reset got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if ({busy, done, idx, c} !== e) begin
        nerr++; $display("FAIL idle_en[%0d] got %h want %h", k, {busy, done, idx, c}, e);
      end
      ncmp++;
    end
    en = 1'b0;
  endtask

  task automatic test_loop();
    int ev[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    logic [8:0] e;
    do_reset();
    do_start(3'd7, 2'b00);
    e = {1'b1, 1'b0, 3'd0, 4'd0};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL loop_start got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      e = {1'b1, (k == 7), 3'(ev[k]), 4'(ev[k])};
      if ({busy, done, idx, c} !== e) begin
        nerr++; $display("FAIL loop[%0d] got %h want %h", k, {busy, done, idx, c}, e);
      end
      ncmp++;
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [8:0] ex[6] = '{ {1'b1, 1'b0, 3'd1, 4'd9},  {1'b1, 1'b0, 3'd2, 4'd1},
                           {1'b1, 1'b0, 3'd3, 4'd14}, {1'b0, 1'b1, 3'd3, 4'd14},
                           {1'b0, 1'b0, 3'd3, 4'd14}, {1'b0, 1'b0, 3'd3, 4'd14} };
    logic [8:0] e;
    do_reset();
    do_write(3'd0, 4'd3); do_write(3'd1, 4'd9);
    do_write(3'd2, 4'd1); do_write(3'd3, 4'd14);
    do_start(3'd3, 2'b01);
    e = {1'b1, 1'b0, 3'd0, 4'd3};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL oneshot_start got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if ({busy, done, idx, c} !== ex[k]) begin
        nerr++; $display("FAIL oneshot[%0d] got %h want %h", k, {busy, done, idx, c}, ex[k]);
      end
      ncmp++;
    end
    en = 1'b0;
  endtask

  task automatic test_pingpong();
    int ev[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    logic [8:0] e;
    do_reset();
    do_start(3'd3, 2'b10);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = {1'b1, (k == 5), 3'(ev[k]), 4'(ev[k])};
      if ({busy, done, idx, c} !== e) begin
        nerr++; $display("FAIL pingpong[%0d] got %h want %h", k, {busy, done, idx, c}, e);
      end
      ncmp++;
    end
    en = 1'b0;
    // last=0 loop: parked at 0, done on every enabled edge
    do_start(3'd0, 2'b00);
    e = {1'b1, 1'b0, 3'd0, 4'd0};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL last0_start got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = {1'b1, 1'b1, 3'd0, 4'd0};
      if ({busy, done, idx, c} !== e) begin
        nerr++; $display("FAIL last0[%0d] got %h want %h", k, {busy, done, idx, c}, e);
      end
      ncmp++;
    end
    en = 1'b0;
  endtask

  task automatic test_hold_restart();
    logic [8:0] e;
    do_reset();
    do_start(3'd7, 2'b00);
    en = 1'b1;
    repeat (5) tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = {1'b1, 1'b0, 3'd5, 4'd5};
      if ({busy, done, idx, c} !== e) begin
        nerr++; $display("FAIL hold[%0d] got %h want %h", k, {busy, done, idx, c}, e);
      end
      ncmp++;
    end
    en = 1'b1;
    tick();
    e = {1'b1, 1'b0, 3'd6, 4'd6};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL resume got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = {1'b1, 1'b0, 3'd0, 4'd0};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL restart got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    tick();
    e = {1'b1, 1'b0, 3'd1, 4'd1};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL restart_step got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    en = 1'b0;
  endtask

  task automatic test_bypass();
    logic [8:0] ex[5] = '{ {1'b1, 1'b0, 3'd5, 4'd5}, {1'b1, 1'b0, 3'd6, 4'd13},
                           {1'b1, 1'b0, 3'd7, 4'd7}, {1'b1, 1'b1, 3'd0, 4'd0},
                           {1'b1, 1'b0, 3'd1, 4'd1} };
    logic [8:0] ey[3] = '{ {1'b1, 1'b0, 3'd1, 4'd1}, {1'b1, 1'b0, 3'd2, 4'd2},
                           {1'b1, 1'b1, 3'd0, 4'd0} };
    logic [8:0] e;
    do_reset();
    do_start(3'd7, 2'b00);
    en = 1'b1;
    repeat (3) tick();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'd11;
    tick();
    e = {1'b1, 1'b0, 3'd4, 4'd11};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL bypass got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    en = 1'b0; wr_addr = 3'd6; wr_data = 4'd13;
    tick();
    wr_en = 1'b0;
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL write_only got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    // last/mode changes while running must be ignored
    last = 3'd2; mode = 2'b01; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if ({busy, done, idx, c} !== ex[k]) begin
        nerr++; $display("FAIL midchg[%0d] got %h want %h", k, {busy, done, idx, c}, ex[k]);
      end
      ncmp++;
    end
    en = 1'b0;
    do_start(3'd2, 2'b00);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({busy, done, idx, c} !== ey[k]) begin
        nerr++; $display("FAIL newlast[%0d] got %h want %h", k, {busy, done, idx, c}, ey[k]);
      end
      ncmp++;
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [8:0] e;
    do_reset();
    do_write(3'd2, 4'd9);
    do_start(3'd7, 2'b00);
    en = 1'b1;
    repeat (2) tick();
    e = {1'b1, 1'b0, 3'd2, 4'd9};
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL pre_rst got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    #2 rst = 1'b0;
    #1;
    e = 9'h000;
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL async_rst got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    tick();
    rst = 1'b1;
    tick();
    if ({busy, done, idx, c} !== e) begin
      nerr++; $display("FAIL post_rst_idle got %h want %h", {busy, done, idx, c}, e);
    end
    ncmp++;
    en = 1'b0;
    do_start(3'd7, 2'b00);
    en = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      e = {1'b1, 1'b0, 3'(k), 4'(k)};
      if ({busy, done, idx, c} !== e) begin
        nerr++; $display("FAIL identity[%0d] got %h want %h", k, {busy, done, idx, c}, e);
      end
      ncmp++;
    end
    en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_loop();
    test_oneshot();
    test_pingpong();
    test_hold_restart();
    test_bypass();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
